// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared defaults, NOP encoding and fetch-entry type for the fetch stage
package ifu_pkg;
  localparam int          ADDR_W_DEF   = 64;
  localparam int          INST_W_DEF   = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INST_W_DEF-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous FIFO with synchronous flush and occupancy count
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full queue is only legal when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
endmodule

// File: rtl/ifu_fetch_queue.sv
// rtl/ifu_fetch_queue.sv - credit-based fetch engine with instruction queue; IFU_PERF_CNT_EN adds perf counters
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
`ifdef IFU_PERF_CNT_EN
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_flush_cnt,
  output logic [63:0]       perf_drop_cnt,
`endif
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [INST_W-1:0] dec_inst,
  output logic [ADDR_W-1:0] dec_pc
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = ADDR_W + INST_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ADDR_W-1:0] redirect_base;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     count;
  logic [CW:0]       credits;
  logic [EW-1:0]     head;
  logic              empty;
  logic              req_fire;
  logic              rsp_drop;
  logic              push;
  logic              pop;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign redirect_base  = {redirect_pc[ADDR_W-1:2], 2'b00};

  // Queued plus in-flight entries never exceed DEPTH, so responses always have a slot.
  assign credits        = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = rst && !redirect_valid && (credits < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (redirect_valid || (drop_cnt != '0));
  assign push           = imem_rsp_valid && !rsp_drop;
  assign pop            = dec_valid && dec_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the old path and must be squashed.
      fetch_pc    <= redirect_base;
      rsp_pc      <= redirect_base;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop_cnt    <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
      if (push)     rsp_pc   <= rsp_pc + ADDR_W'(4);
      if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    end
  end

  fetch_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (push),
    .push_data({rsp_pc, imem_rsp_data}),
    .pop      (pop),
    .pop_data (head),
    .count    (count),
    .empty    (empty)
  );

  assign dec_valid = !empty;
  assign dec_pc    = empty ? '0 : head[EW-1:INST_W];
  assign dec_inst  = empty ? '0 : head[INST_W-1:0];

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 64'(pop);
      perf_flush_cnt <= perf_flush_cnt + 64'(redirect_valid);
      perf_drop_cnt  <= perf_drop_cnt + 64'(rsp_drop);
    end
  end
`endif
endmodule
